// File: rtl/rhs2116_link_pkg.sv
// Shared constants and the transmit state type for the RHS2116 coax link.
// Both the encoder and the receive-side frame sync import this package.
package rhs2116_link_pkg;

  localparam logic [7:0] SYNC_WORD_DEFAULT = 8'hA5;
  localparam int         FRAME_DATA_BITS   = 32;
  localparam int         CRC_BITS          = 8;
  localparam int         SYNC_BITS         = 8;
  localparam logic [7:0] CRC_POLY          = 8'h07;
  localparam int         FRAME_BITS        = SYNC_BITS + FRAME_DATA_BITS + CRC_BITS;

  typedef enum logic [2:0] {
    OFF,
    IDLE,
    SYNC,
    DATA,
    CRC
  } tx_state_e;

endpackage

// File: rtl/crc8_serial.sv
// Bit-serial CRC-8 (x^8+x^2+x+1), MSB first, init 0, no reflection or final XOR.
// Shared between the link encoder and the receive-side frame checker.
module crc8_serial
  import rhs2116_link_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                en,
  input  logic                bit_in,
  output logic [CRC_BITS-1:0] crc
);

  logic fb;

  assign fb = crc[CRC_BITS-1] ^ bit_in;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc <= '0;
    end else if (clear) begin
      crc <= '0;
    end else if (en) begin
      crc <= {crc[CRC_BITS-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
    end
  end

endmodule

// File: rtl/rhs2116_link_encoder.sv
// Frames 32-bit words as SYNC + DATA + CRC8 and Manchester-encodes them onto
// the coax line, sending idle bits between frames to keep the far-end CDR locked.
//
// state | meaning
// OFF   | line held low, bit timing stopped
// IDLE  | repeating IDLE_BIT, waiting for a buffered word
// SYNC  | sending SYNC_WORD, MSB first
// DATA  | sending the 32 data bits, MSB first, feeding the CRC
// CRC   | sending the CRC-8 of the data bits, MSB first
module rhs2116_link_encoder
  import rhs2116_link_pkg::*;
#(
  parameter int         HALF_BIT_CYCLES = 2,
  parameter logic [7:0] SYNC_WORD       = SYNC_WORD_DEFAULT,
  parameter logic       IDLE_BIT        = 1'b0
) (
  input  logic        clk_link,
  input  logic        rst,
  input  logic        tx_enable,
  input  logic [31:0] din,
  input  logic        din_valid,
  output logic        din_ready,
  output logic        manch_out,
  output logic        tx_busy,
  output logic        frame_sent
);

  localparam int            HW        = (HALF_BIT_CYCLES > 1) ? $clog2(HALF_BIT_CYCLES) : 1;
  localparam logic [HW-1:0] HALF_LAST = HW'(HALF_BIT_CYCLES - 1);

  tx_state_e                  state, state_nxt;
  logic [HW-1:0]              half_cnt;
  logic                       phase;
  logic [4:0]                 bits_left, bits_left_nxt;
  logic [FRAME_DATA_BITS-1:0] buf_q, shreg;
  logic                       buf_full;
  logic                       bit_tick, accept, load, crc_clear, crc_en;
  logic                       cur_bit, last_crc_bit;
  logic [CRC_BITS-1:0]        crc;

  assign bit_tick  = (state != OFF) && phase && (half_cnt == HALF_LAST);
  assign din_ready = !buf_full && !rst;
  assign accept    = din_valid && din_ready;
  assign tx_busy   = buf_full || (state inside {SYNC, DATA, CRC});

  always_ff @(posedge clk_link or posedge rst) begin
    if (rst) begin
      state <= OFF;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    bits_left_nxt = bits_left;
    load          = 1'b0;
    crc_en        = 1'b0;
    cur_bit       = IDLE_BIT;
    last_crc_bit  = 1'b0;
    case (state)
      OFF: begin
        if (tx_enable) state_nxt = IDLE;
      end
      IDLE: begin
        if (bit_tick) begin
          if (buf_full) begin
            state_nxt     = SYNC;
            load          = 1'b1;
            bits_left_nxt = 5'(SYNC_BITS - 1);
          end else if (!tx_enable) begin
            state_nxt = OFF;
          end
        end
      end
      SYNC: begin
        cur_bit = SYNC_WORD[bits_left[2:0]];
        if (bit_tick) begin
          if (bits_left == '0) begin
            state_nxt     = DATA;
            bits_left_nxt = 5'(FRAME_DATA_BITS - 1);
          end else begin
            bits_left_nxt = bits_left - 5'd1;
          end
        end
      end
      DATA: begin
        cur_bit = shreg[bits_left];
        crc_en  = bit_tick;
        if (bit_tick) begin
          if (bits_left == '0) begin
            state_nxt     = CRC;
            bits_left_nxt = 5'(CRC_BITS - 1);
          end else begin
            bits_left_nxt = bits_left - 5'd1;
          end
        end
      end
      CRC: begin
        cur_bit = crc[bits_left[2:0]];
        if (bit_tick) begin
          if (bits_left == '0) begin
            last_crc_bit = 1'b1;
            // A buffered word goes straight out with no idle bit in between.
            if (buf_full) begin
              state_nxt     = SYNC;
              load          = 1'b1;
              bits_left_nxt = 5'(SYNC_BITS - 1);
            end else if (tx_enable) begin
              state_nxt = IDLE;
            end else begin
              state_nxt = OFF;
            end
          end else begin
            bits_left_nxt = bits_left - 5'd1;
          end
        end
      end
      default: state_nxt = OFF;
    endcase
  end

  assign crc_clear = load;

  always_ff @(posedge clk_link or posedge rst) begin
    if (rst) begin
      half_cnt   <= '0;
      phase      <= 1'b0;
      bits_left  <= '0;
      buf_q      <= '0;
      shreg      <= '0;
      buf_full   <= 1'b0;
      manch_out  <= 1'b0;
      frame_sent <= 1'b0;
    end else begin
      bits_left  <= bits_left_nxt;
      // frame_sent is registered so it lines up with the registered line output.
      frame_sent <= last_crc_bit;
      manch_out  <= (state == OFF) ? 1'b0 : (phase ? cur_bit : ~cur_bit);
      if (state == OFF) begin
        half_cnt <= '0;
        phase    <= 1'b0;
      end else if (half_cnt == HALF_LAST) begin
        half_cnt <= '0;
        phase    <= ~phase;
      end else begin
        half_cnt <= half_cnt + 1'b1;
      end
      if (load) begin
        shreg    <= buf_q;
        buf_full <= 1'b0;
      end else if (accept) begin
        buf_q    <= din;
        buf_full <= 1'b1;
      end
    end
  end

  crc8_serial u_crc (
    .clk    (clk_link),
    .rst    (rst),
    .clear  (crc_clear),
    .en     (crc_en),
    .bit_in (shreg[bits_left]),
    .crc    (crc)
  );

endmodule

// File: tb/tb_rhs2116_link_encoder.sv
// Scoreboard bench: accepted words are queued, an independent line decoder
// recovers frames from manch_out and compares them with a CRC reference.
module tb_rhs2116_link_encoder;

  localparam int H = 2;
  localparam logic [7:0] SYNC = 8'hA5;

  logic        clk_link = 1'b0;
  logic        rst = 1'b1;
  logic        tx_enable = 1'b0;
  logic [31:0] din = '0;
  logic        din_valid = 1'b0;
  logic        din_ready, manch_out, tx_busy, frame_sent;

  rhs2116_link_encoder #(
    .HALF_BIT_CYCLES (H),
    .SYNC_WORD       (SYNC),
    .IDLE_BIT        (1'b0)
  ) dut (
    .clk_link   (clk_link),
    .rst        (rst),
    .tx_enable  (tx_enable),
    .din        (din),
    .din_valid  (din_valid),
    .din_ready  (din_ready),
    .manch_out  (manch_out),
    .tx_busy    (tx_busy),
    .frame_sent (frame_sent)
  );

  always #5 clk_link = ~clk_link;

  int cyc = 0;
  always @(posedge clk_link) cyc++;

  int n_checks = 0;
  int n_fail = 0;
  logic [31:0] exp_q[$];

  task automatic check(input string name, input logic [39:0] act, input logic [39:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // CRC as the remainder of polynomial long division of data*x^8 by 0x107.
  function automatic logic [7:0] ref_crc(input logic [31:0] d);
    logic [39:0] r;
    r = {d, 8'h00};
    for (int i = 39; i >= 8; i--)
      if (r[i]) r[i -: 9] = r[i -: 9] ^ 9'h107;
    return r[7:0];
  endfunction

  // Line decoder / monitor
  logic        prev = 1'b0, h1 = 1'b0, aligned = 1'b0, in_frame = 1'b0, v, frame_done;
  logic [7:0]  hunt = '0;
  logic [39:0] fbits = '0;
  logic [31:0] last_data = '0, w;
  logic [7:0]  last_crc = '0;
  int c = 0, nbits = 0, hunt_bits = 0, last_gap = -1, bit_start = 0, sync_start = 0, frames_rx = 0;

  initial begin : monitor
    forever begin
      @(negedge clk_link);
      v = manch_out;
      frame_done = 1'b0;
      if (rst) begin
        aligned = 1'b0; in_frame = 1'b0; hunt = '0; hunt_bits = 0;
      end else if (!aligned) begin
        if (!prev && v) begin aligned = 1'b1; c = 0; bit_start = cyc; end
      end else begin
        c++;
        if (c == 2*H) begin c = 0; bit_start = cyc; end
      end
      if (aligned && c == H-1) h1 = v;
      if (aligned && c == 2*H-1) begin
        if (h1 == v) begin
          if (v) check("manchester_violation", 40'(h1), 40'(~v));
          aligned = 1'b0; in_frame = 1'b0; hunt = '0; hunt_bits = 0;
        end else if (!in_frame) begin
          hunt = {hunt[6:0], v};
          hunt_bits++;
          if (hunt == SYNC) begin
            in_frame = 1'b1; nbits = 0;
            sync_start = bit_start - 7*2*H;
            last_gap = hunt_bits - 8;
          end
        end else begin
          fbits = {fbits[38:0], v};
          nbits++;
          if (nbits == 40) begin
            frame_done = 1'b1;
            last_data = fbits[39:8];
            last_crc = fbits[7:0];
            check("frame_length_cycles", 40'(cyc - sync_start), 40'(48*2*H - 1));
            check("frame_sent_at_end", 40'(frame_sent), 40'd1);
            if (exp_q.size() == 0) begin
              check("unexpected_frame_data", 40'(last_data), 40'hFFFF_FFFF_FF);
            end else begin
              w = exp_q.pop_front();
              check("frame_data", 40'(last_data), 40'(w));
              check("frame_crc", 40'(last_crc), 40'(ref_crc(w)));
            end
            frames_rx++;
            in_frame = 1'b0; hunt = '0; hunt_bits = 0;
          end
        end
      end
      if (frame_sent && !frame_done) check("spurious_frame_sent", 40'(frame_sent), 40'd0);
      prev = v;
    end
  end

  task automatic send_word(input logic [31:0] wd);
    int n;
    n = 0;
    @(negedge clk_link);
    din = wd;
    din_valid = 1'b1;
    while (!din_ready && n < 1000) begin @(negedge clk_link); n++; end
    if (!din_ready) begin
      check("din_ready_timeout", 40'(din_ready), 40'd1);
    end else begin
      exp_q.push_back(wd);
      @(posedge clk_link);
    end
    #1 din_valid = 1'b0;
  endtask

  task automatic wait_frames(input int target);
    int n;
    n = 0;
    while (frames_rx < target && n < 5000) begin @(negedge clk_link); n++; end
    check("frames_received", 40'(frames_rx), 40'(target));
  endtask

  task automatic wait_in_data();
    int n;
    n = 0;
    while (!(in_frame && nbits >= 8) && n < 2000) begin @(negedge clk_link); n++; end
    check("reached_data_phase", 40'(in_frame && nbits >= 8), 40'd1);
  endtask

  initial begin : stim
    int ones, trans, base, highs, busy;
    logic p;
    repeat (3) @(negedge clk_link);
    check("rst_manch_out", 40'(manch_out), 40'd0);
    check("rst_tx_busy", 40'(tx_busy), 40'd0);
    check("rst_din_ready", 40'(din_ready), 40'd0);
    check("rst_frame_sent", 40'(frame_sent), 40'd0);

    // Idle line after enable
    rst = 1'b0;
    tx_enable = 1'b1;
    repeat (8) @(negedge clk_link);
    ones = 0; trans = 0; p = manch_out;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_link);
      ones += int'(manch_out);
      if (manch_out != p) trans++;
      p = manch_out;
    end
    check("idle_ones", 40'(ones), 40'd20);
    check("idle_toggle_ok", 40'(trans >= 19), 40'd1);
    check("idle_din_ready", 40'(din_ready), 40'd1);
    check("idle_tx_busy", 40'(tx_busy), 40'd0);
    check("idle_no_frames", 40'(frames_rx), 40'd0);

    // Single known frame
    send_word(32'h0000_0001);
    wait_frames(1);
    check("word1_data", 40'(last_data), 40'h0000_0001);
    check("word1_crc", 40'(last_crc), 40'h07);
    repeat (12) @(negedge clk_link);
    check("back_to_idle", 40'(aligned && !in_frame), 40'd1);
    check("after_frame_tx_busy", 40'(tx_busy), 40'd0);

    // Back-to-back frames
    base = frames_rx;
    send_word(32'h0000_0000);
    send_word(32'hDEAD_BEEF);
    check("b2b_din_ready_full", 40'(din_ready), 40'd0);
    check("b2b_tx_busy", 40'(tx_busy), 40'd1);
    wait_frames(base + 2);
    check("b2b_no_gap", 40'(last_gap), 40'd0);
    check("b2b_second_data", 40'(last_data), 40'hDEAD_BEEF);

    // tx_enable drop mid-DATA with a word buffered
    base = frames_rx;
    send_word(32'h1234_5678);
    wait_in_data();
    send_word(32'h9ABC_DEF0);
    tx_enable = 1'b0;
    wait_frames(base + 2);
    @(negedge clk_link);
    highs = 0; busy = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk_link);
      highs += int'(manch_out);
      busy += int'(tx_busy);
    end
    check("off_line_low", 40'(highs), 40'd0);
    check("off_tx_busy", 40'(busy), 40'd0);
    tx_enable = 1'b1;
    base = frames_rx;
    send_word(32'hCAFE_F00D);
    wait_frames(base + 1);
    check("restart_data", 40'(last_data), 40'hCAFE_F00D);

    // Reset mid-DATA drops the frame and the buffered word
    send_word(32'h5555_AAAA);
    wait_in_data();
    send_word(32'h0F0F_0F0F);
    @(posedge clk_link);
    #1 rst = 1'b1;
    #1;
    check("rst_mid_manch_out", 40'(manch_out), 40'd0);
    check("rst_mid_tx_busy", 40'(tx_busy), 40'd0);
    check("rst_mid_din_ready", 40'(din_ready), 40'd0);
    exp_q.delete();
    repeat (16) @(negedge clk_link);
    rst = 1'b0;
    base = frames_rx;
    send_word(32'h3C3C_A5A5);
    wait_frames(base + 1);
    check("post_reset_data", 40'(last_data), 40'h3C3C_A5A5);

    // Random streaming with random gaps
    base = frames_rx;
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(0, 300)) @(negedge clk_link);
      send_word($urandom);
    end
    wait_frames(base + 200);
    check("queue_drained", 40'(exp_q.size()), 40'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rhs2116_link_encoder.md
Name: rhs2116_link_encoder

Overview:
Transmit side of the RHS2116 coax link, in the clk_link (200 MHz) domain. It accepts 32-bit sample words over a valid/ready handshake and frames each word as SYNC(8) + DATA(32) + CRC8(8), MSB first. Frames are Manchester-encoded onto a single-ended coax output whose rate and format match the 4x-oversampling CDR and frame sync on the receive end. Between frames it sends idle bits so the far-end CDR stays locked.

Parameters:
HALF_BIT_CYCLES, 2, clk_link cycles per Manchester half-bit (bit period = 2*HALF_BIT_CYCLES; default gives 50 Mb/s)
SYNC_WORD, 8'hA5, frame sync byte
IDLE_BIT, 1'b0, bit value sent between frames

Ports:
clk_link  input  1  link clock (200 MHz); the only clock
rst  input  1  asynchronous, active-high reset
tx_enable  input  1  1 = drive line; 0 = quiesce after the current frame
din  input  32  word to transmit
din_valid  input  1  din is valid
din_ready  output  1  encoder can accept a word this cycle
manch_out  output  1  registered Manchester line output
tx_busy  output  1  a frame is in SYNC/DATA/CRC, or a word is buffered
frame_sent  output  1  one-cycle pulse on the last clock of each frame's final CRC half-bit

Behaviour:
- Reset (async assert, sync release): manch_out=0, tx_busy=0, frame_sent=0, din_ready=0 while rst=1, buffer empty, state OFF. Reset mid-frame aborts the frame immediately and drops the buffered word.
- Buffer: one 32-bit holding register. din_ready = !buf_full && !rst. A transfer occurs on din_valid && din_ready and sets buf_full.
- Timing: half-cycle counter 0..HALF_BIT_CYCLES-1 and a phase bit (first/second half). bit_tick marks the last cycle of a bit. All state changes happen on bit_tick only.
- Encoding: bit 1 = low then high; bit 0 = high then low. manch_out is registered, so the line shows one cycle of latency from the internal phase.
- States:
  - OFF: line held at 0, counters held. Go to IDLE when tx_enable=1, and start the first idle bit on the next cycle.
  - IDLE: sends IDLE_BIT repeatedly. On bit_tick: if buf_full, go to SYNC, move the buffer into the shift register, clear buf_full and CRC. Otherwise, if !tx_enable, go to OFF.
  - SYNC: 8 bits of SYNC_WORD. Then DATA.
  - DATA: 32 bits, MSB first. The CRC updates on each data bit. Then CRC.
  - CRC: 8 bits of CRC-8, MSB first. On the final bit_tick, pulse frame_sent. Then:
    - buf_full: go to SYNC (back-to-back, no idle bit between frames).
    - else tx_enable=1: go to IDLE.
    - else: go to OFF.
- CRC-8: polynomial x^8+x^2+x+1 (0x07), init 0x00, no reflection, no final XOR, computed over the 32 data bits only.
- Frame length is 48 bits = 48*2*HALF_BIT_CYCLES cycles (192 at default).
- A new word can be accepted as soon as the previous one moves to the shift register, which gives full-rate streaming with no gaps.
- tx_enable deassertion never truncates a frame. A buffered word is still sent before going to OFF.
- din_valid while buf_full: held off by din_ready=0; no data loss.
- tx_busy = (state in SYNC/DATA/CRC) || buf_full.

Decomposition:
- Package rhs2116_link_pkg holds:
  - SYNC_WORD default, FRAME_DATA_BITS=32, CRC_BITS=8, CRC_POLY=8'h07, SYNC_BITS=8
  - tx state enum {OFF, IDLE, SYNC, DATA, CRC}
- The receive-side frame sync will share this package.
- One sub-module: crc8_serial, with inputs clk, rst, clear, en and bit_in, and output crc[7:0]. The receiver reuses it for checking.

Test Plan:
- Reset release, tx_enable=1, no data -> line toggles high/low every 2 cycles (idle 0 bits); din_ready=1; tx_busy=0; frame_sent never pulses.
- Send 32'h00000001 -> decoded bits are A5 / 00000001 / CRC 8'h07; frame_sent pulses once, 192 cycles after the SYNC start; line returns to idle bits.
- Send 32'h00000000 then 32'hDEADBEEF back-to-back with din_valid held -> second SYNC starts on the cycle after the first CRC ends; no idle bit between; din_ready drops only while the buffer is full.
- Drop tx_enable mid-DATA with a word buffered -> both frames complete, then manch_out=0 steady; the OFF→IDLE restart works when tx_enable is reasserted.
- Assert rst mid-DATA -> manch_out=0 and tx_busy=0 in the same cycle; buffered word lost; after release, the first frame sent comes from the next word accepted.
- Loopback of manch_out into rhs2116_link_decoder with 1000 random words -> all words received in order, frame_error=0, cdr_locked stays high.
